bus_addr_decoder: RTL and testbench

- Upstream stage of the 8088 bus memory/IO model.
- Demultiplexes the 8088 AD bus into a held 20-bit address and tracks each bus cycle with an FSM.
- Decodes the address into one-hot chip selects for two memory banks and two IO windows.
- Inserts programmable wait states through READY.
- Its ADDR and CS outputs drive the Address and CS inputs of the downstream memory/IO slaves.

---
 rtl/bus_pkg.sv | 48 ++++
 rtl/addr_latch.sv | 41 ++++
 rtl/bus_addr_decoder.sv | 185 ++++++++++++++++++
 tb/tb_bus_addr_decoder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus_pkg
// Purpose  : Shared types, chip-select indices and address decode for the
//            8088 bus address decoder.
// Revision : 1.0  initial release
// ============================================================================
package bus_pkg;

  typedef enum logic [4:0] {
    S_IDLE = 5'b00001,
    S_ADDR = 5'b00010,
    S_WAIT = 5'b00100,
    S_ACT  = 5'b01000,
    S_END  = 5'b10000
  } bus_state_e;

  localparam int CS_MEM0 = 0;
  localparam int CS_MEM1 = 1;
  localparam int CS_IO0  = 2;
  localparam int CS_IO1  = 3;

  localparam int WAIT_W = 3;

  // IO window 0 is tested first so it wins when both pages are equal.
  function automatic logic [3:0] addr_to_cs(
    input logic [19:0] addr,
    input logic        io_m,
    input logic [7:0]  io0_page,
    input logic [7:0]  io1_page
  );
    logic [3:0]  cs;
    logic [10:0] unused_addr_bits;
    cs               = '0;
    unused_addr_bits = {addr[18:16], addr[7:0]};
    if (!io_m) begin
      if (addr[19]) cs[CS_MEM1] = 1'b1;
      else          cs[CS_MEM0] = 1'b1;
    end else if (addr[15:8] == io0_page) begin
      cs[CS_IO0] = 1'b1;
    end else if (addr[15:8] == io1_page) begin
      cs[CS_IO1] = 1'b1;
    end
    return cs;
  endfunction

endpackage
`default_nettype wire

// File: rtl/addr_latch.sv
`default_nettype none
// ============================================================================
// Module   : addr_latch
// Purpose  : 8282-style address latch: transparent while ALE is high, holds the
//            value registered on the last ALE-high clock edge otherwise.
// Revision : 1.0  initial release
// ============================================================================
module addr_latch
  import bus_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_ale,
  input  logic [7:0]  i_ad,
  input  logic [11:0] i_a_hi,
  input  logic        i_io_m,
  output logic [19:0] o_addr,
  output logic        o_io_m
);

  logic [19:0] r_addr;
  logic        r_io_m;
  logic [19:0] w_live_addr;

  assign w_live_addr = {i_a_hi, i_ad};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr <= '0;
      r_io_m <= 1'b0;
    end else if (i_ale) begin
      r_addr <= w_live_addr;
      r_io_m <= i_io_m;
    end
  end

  assign o_addr = i_ale ? w_live_addr : r_addr;
  assign o_io_m = i_ale ? i_io_m      : r_io_m;

endmodule
`default_nettype wire

// File: rtl/bus_addr_decoder.sv
`default_nettype none
// ============================================================================
// Module   : bus_addr_decoder
// Purpose  : 8088 AD-bus demux, bus-cycle FSM, chip-select decode and wait
//            state generation. Optional macro: BUS_TIMEOUT_EN (S_ADDR timeout).
// Revision : 1.0  initial release
// ============================================================================
module bus_addr_decoder
  import bus_pkg::*;
#(
  parameter int          WAIT_MEM    = 1,
  parameter int          WAIT_IO     = 3,
  parameter logic [15:0] IO0_BASE    = 16'h0000,
  parameter logic [15:0] IO1_BASE    = 16'h1C00,
  parameter int          TIMEOUT_CYC = 16
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        ALE,
  input  logic [7:0]  AD_IN,
  input  logic [11:0] A_HI,
  input  logic        IO_M,
  input  logic        RD_N,
  input  logic        WR_N,
  output logic [19:0] ADDR,
  output logic [3:0]  CS,
  output logic        READY,
  output logic        BUS_ERR,
  output logic        CYCLE_ACTIVE
);

  localparam logic [WAIT_W-1:0] c_WAIT_MEM = WAIT_W'(WAIT_MEM);
  localparam logic [WAIT_W-1:0] c_WAIT_IO  = WAIT_W'(WAIT_IO);
  localparam logic [7:0]        c_IO0_PAGE = IO0_BASE[15:8];
  localparam logic [7:0]        c_IO1_PAGE = IO1_BASE[15:8];

  bus_state_e        r_state, w_next;
  logic [WAIT_W-1:0] r_wait_cnt, w_wait_next;
  logic [19:0]       w_addr;
  logic              w_io_m;
  logic [3:0]        w_cs_dec;
  logic              w_cs_en;
  logic              w_mapped;
  logic              w_strobe;
  logic              w_both;
  logic [WAIT_W-1:0] w_wait_eff;
  logic              w_ready;
  logic              w_err;
  logic              w_timeout;

  addr_latch u_latch (
    .i_clk   (CLK),
    .i_rst_n (RESET_N),
    .i_ale   (ALE),
    .i_ad    (AD_IN),
    .i_a_hi  (A_HI),
    .i_io_m  (IO_M),
    .o_addr  (w_addr),
    .o_io_m  (w_io_m)
  );

  assign w_cs_dec   = addr_to_cs(w_addr, w_io_m, c_IO0_PAGE, c_IO1_PAGE);
  assign w_mapped   = |w_cs_dec;
  assign w_strobe   = RD_N ^ WR_N;
  assign w_both     = ~RD_N & ~WR_N;
  // Unmapped cycles complete like a zero-wait access.
  assign w_wait_eff = !w_mapped ? '0 : (w_io_m ? c_WAIT_IO : c_WAIT_MEM);
  assign w_cs_en    = ALE | (r_state == S_ADDR) | (r_state == S_WAIT) | (r_state == S_ACT);

`ifdef BUS_TIMEOUT_EN
  localparam int c_TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [c_TO_W-1:0] r_to_cnt;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_to_cnt <= '0;
    end else if (r_state == S_ADDR && w_next == S_ADDR && !ALE) begin
      r_to_cnt <= r_to_cnt + c_TO_W'(1);
    end else begin
      r_to_cnt <= '0;
    end
  end

  assign w_timeout = (r_to_cnt == c_TO_W'(TIMEOUT_CYC - 1));
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;

  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_next;
      r_wait_cnt <= w_wait_next;
    end
  end

  // The strobe cycle in S_ADDR is itself the first wait state, so S_WAIT
  // holds for the remaining W-1 cycles.
  always_comb begin
    w_next      = r_state;
    w_wait_next = r_wait_cnt;
    w_ready     = 1'b1;
    w_err       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (ALE) w_next = S_ADDR;
      end
      S_ADDR: begin
        if (w_both) begin
          w_err       = 1'b1;
          w_next      = S_IDLE;
          w_wait_next = '0;
        end else if (w_strobe) begin
          w_err = ~w_mapped;
          if (w_wait_eff != '0) begin
            w_ready     = 1'b0;
            w_wait_next = w_wait_eff - WAIT_W'(1);
            w_next      = (w_wait_eff > WAIT_W'(1)) ? S_WAIT : S_ACT;
          end else begin
            w_wait_next = '0;
            w_next      = S_ACT;
          end
        end else if (w_timeout) begin
          w_err  = 1'b1;
          w_next = S_IDLE;
        end
      end
      S_WAIT: begin
        w_ready = 1'b0;
        if (w_both) begin
          w_err       = 1'b1;
          w_next      = S_IDLE;
          w_wait_next = '0;
        end else if (ALE) begin
          w_err       = 1'b1;
          w_next      = S_ADDR;
          w_wait_next = '0;
        end else if (r_wait_cnt <= WAIT_W'(1)) begin
          w_next      = S_ACT;
          w_wait_next = '0;
        end else begin
          w_wait_next = r_wait_cnt - WAIT_W'(1);
        end
      end
      S_ACT: begin
        if (w_both) begin
          w_err  = 1'b1;
          w_next = S_IDLE;
        end else if (ALE) begin
          w_err  = 1'b1;
          w_next = S_ADDR;
        end else if (RD_N && WR_N) begin
          w_next = S_END;
        end
      end
      S_END: begin
        if (w_both) begin
          w_err  = 1'b1;
          w_next = S_IDLE;
        end else if (ALE) begin
          w_next = S_ADDR;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next      = S_IDLE;
        w_wait_next = '0;
      end
    endcase
  end

  assign ADDR         = w_addr;
  assign CS           = w_cs_en ? w_cs_dec : 4'b0000;
  assign READY        = w_ready;
  assign BUS_ERR      = w_err;
  assign CYCLE_ACTIVE = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_bus_addr_decoder.sv
`default_nettype none
// Directed bench for bus_addr_decoder: memory/IO cycles, wait states, error
// pulses, asynchronous reset and the S_ADDR timeout option.
module tb_bus_addr_decoder;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        ALE;
  logic [7:0]  AD_IN;
  logic [11:0] A_HI;
  logic        IO_M;
  logic        RD_N;
  logic        WR_N;
  logic [19:0] ADDR;
  logic [3:0]  CS;
  logic        READY;
  logic        BUS_ERR;
  logic        CYCLE_ACTIVE;

  int n_total = 0;
  int n_pass  = 0;

  bus_addr_decoder #(
    .WAIT_MEM    (1),
    .WAIT_IO     (3),
    .IO0_BASE    (16'h0000),
    .IO1_BASE    (16'h1C00),
    .TIMEOUT_CYC (16)
  ) dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .ALE          (ALE),
    .AD_IN        (AD_IN),
    .A_HI         (A_HI),
    .IO_M         (IO_M),
    .RD_N         (RD_N),
    .WR_N         (WR_N),
    .ADDR         (ADDR),
    .CS           (CS),
    .READY        (READY),
    .BUS_ERR      (BUS_ERR),
    .CYCLE_ACTIVE (CYCLE_ACTIVE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Inputs change 1 time unit after the rising edge; checks run 3 units later.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic put_addr(input logic [19:0] a, input logic io);
    A_HI  = a[19:8];
    AD_IN = a[7:0];
    IO_M  = io;
  endtask

  initial begin
    RESET_N = 1'b0;
    ALE     = 1'b0;
    AD_IN   = 8'h00;
    A_HI    = 12'h000;
    IO_M    = 1'b0;
    RD_N    = 1'b1;
    WR_N    = 1'b1;

    // Reset state
    cyc(); cyc(); #3;
    chk("rst_addr",   32'(ADDR), 32'h0);
    chk("rst_cs",     32'(CS), 32'h0);
    chk("rst_ready",  32'(READY), 32'h1);
    chk("rst_err",    32'(BUS_ERR), 32'h0);
    chk("rst_active", 32'(CYCLE_ACTIVE), 32'h0);
    cyc(); RESET_N = 1'b1;

    // Memory read at 0x12345, one wait state
    cyc(); ALE = 1'b1; put_addr(20'h12345, 1'b0); #3;
    chk("mr_ale_cs",   32'(CS), 32'h1);
    chk("mr_ale_addr", 32'(ADDR), 32'h12345);
    chk("mr_ale_rdy",  32'(READY), 32'h1);
    cyc(); ALE = 1'b0; AD_IN = 8'hAA; RD_N = 1'b0; #3;
    chk("mr_s1_rdy",  32'(READY), 32'h0);
    chk("mr_s1_addr", 32'(ADDR), 32'h12345);
    chk("mr_s1_cs",   32'(CS), 32'h1);
    chk("mr_s1_act",  32'(CYCLE_ACTIVE), 32'h1);
    cyc(); #3;
    chk("mr_s2_rdy", 32'(READY), 32'h1);
    chk("mr_s2_cs",  32'(CS), 32'h1);
    cyc(); #3;
    chk("mr_s3_rdy", 32'(READY), 32'h1);
    cyc(); RD_N = 1'b1; #3;
    chk("mr_rel_cs",  32'(CS), 32'h1);
    chk("mr_rel_rdy", 32'(READY), 32'h1);
    cyc(); #3;
    chk("mr_end_cs",  32'(CS), 32'h0);
    chk("mr_end_act", 32'(CYCLE_ACTIVE), 32'h1);
    cyc(); #3;
    chk("mr_idle_act",  32'(CYCLE_ACTIVE), 32'h0);
    chk("mr_idle_addr", 32'(ADDR), 32'h12345);

    // IO write to 0x1C40, three wait states, IO window 1
    cyc(); ALE = 1'b1; put_addr(20'h01C40, 1'b1); #3;
    chk("iw_ale_cs", 32'(CS), 32'h8);
    cyc(); ALE = 1'b0; AD_IN = 8'h5A; WR_N = 1'b0; #3;
    chk("iw_w1_rdy", 32'(READY), 32'h0);
    chk("iw_w1_err", 32'(BUS_ERR), 32'h0);
    chk("iw_w1_cs",  32'(CS), 32'h8);
    cyc(); #3;
    chk("iw_w2_rdy", 32'(READY), 32'h0);
    chk("iw_w2_err", 32'(BUS_ERR), 32'h0);
    cyc(); #3;
    chk("iw_w3_rdy", 32'(READY), 32'h0);
    cyc(); #3;
    chk("iw_act_rdy", 32'(READY), 32'h1);
    chk("iw_act_err", 32'(BUS_ERR), 32'h0);
    chk("iw_act_cs",  32'(CS), 32'h8);
    cyc(); WR_N = 1'b1; #3;
    chk("iw_rel_err", 32'(BUS_ERR), 32'h0);
    cyc(); #3;
    chk("iw_end_cs", 32'(CS), 32'h0);
    cyc(); #3;
    chk("iw_idle_act", 32'(CYCLE_ACTIVE), 32'h0);

    // IO read to unmapped port 0x0500
    cyc(); ALE = 1'b1; put_addr(20'h00500, 1'b1); #3;
    chk("un_ale_cs",  32'(CS), 32'h0);
    chk("un_ale_err", 32'(BUS_ERR), 32'h0);
    cyc(); ALE = 1'b0; RD_N = 1'b0; #3;
    chk("un_stb_err", 32'(BUS_ERR), 32'h1);
    chk("un_stb_rdy", 32'(READY), 32'h1);
    chk("un_stb_cs",  32'(CS), 32'h0);
    cyc(); RD_N = 1'b1; #3;
    chk("un_act_err", 32'(BUS_ERR), 32'h0);
    cyc(); cyc(); #3;
    chk("un_idle_act", 32'(CYCLE_ACTIVE), 32'h0);

    // Both strobes low in S_ADDR at 0x80000
    cyc(); ALE = 1'b1; put_addr(20'h80000, 1'b0); #3;
    chk("ds_ale_cs", 32'(CS), 32'h2);
    cyc(); ALE = 1'b0; RD_N = 1'b0; WR_N = 1'b0; #3;
    chk("ds_err", 32'(BUS_ERR), 32'h1);
    chk("ds_cs",  32'(CS), 32'h2);
    cyc(); RD_N = 1'b1; WR_N = 1'b1; #3;
    chk("ds_next_cs",  32'(CS), 32'h0);
    chk("ds_next_act", 32'(CYCLE_ACTIVE), 32'h0);
    chk("ds_next_err", 32'(BUS_ERR), 32'h0);

    // Asynchronous reset in the middle of S_WAIT
    cyc(); ALE = 1'b1; put_addr(20'h01C40, 1'b1);
    cyc(); ALE = 1'b0; WR_N = 1'b0;
    cyc(); #3;
    chk("ar_wait_rdy", 32'(READY), 32'h0);
    chk("ar_wait_act", 32'(CYCLE_ACTIVE), 32'h1);
    #2 RESET_N = 1'b0;
    #1;
    chk("ar_cs",   32'(CS), 32'h0);
    chk("ar_rdy",  32'(READY), 32'h1);
    chk("ar_act",  32'(CYCLE_ACTIVE), 32'h0);
    chk("ar_addr", 32'(ADDR), 32'h0);
    chk("ar_err",  32'(BUS_ERR), 32'h0);
    WR_N = 1'b1;
    cyc(); RESET_N = 1'b1;

    // ALE during S_WAIT aborts and re-opens the latch
    cyc(); ALE = 1'b1; put_addr(20'h01C40, 1'b1);
    cyc(); ALE = 1'b0; WR_N = 1'b0;
    cyc(); ALE = 1'b1; WR_N = 1'b1; put_addr(20'h00010, 1'b1); #3;
    chk("ab_err",  32'(BUS_ERR), 32'h1);
    chk("ab_cs",   32'(CS), 32'h4);
    chk("ab_addr", 32'(ADDR), 32'h00010);
    cyc(); ALE = 1'b0; AD_IN = 8'hFF; #3;
    chk("ab_addr_act", 32'(CYCLE_ACTIVE), 32'h1);
    chk("ab_addr_cs",  32'(CS), 32'h4);
    chk("ab_addr_err", 32'(BUS_ERR), 32'h0);
    chk("ab_addr_hold", 32'(ADDR), 32'h00010);
    RD_N = 1'b0; WR_N = 1'b0;
    cyc(); RD_N = 1'b1; WR_N = 1'b1; #3;
    chk("ab_idle_act", 32'(CYCLE_ACTIVE), 32'h0);

    // S_ADDR with no strobe
    cyc(); ALE = 1'b1; put_addr(20'h12345, 1'b0);
    begin
      logic early_err;
      early_err = 1'b0;
`ifdef BUS_TIMEOUT_EN
      for (int k = 1; k <= 15; k++) begin
        cyc(); ALE = 1'b0; #3;
        if (BUS_ERR) early_err = 1'b1;
      end
      chk("to_no_early_err", 32'(early_err), 32'h0);
      cyc(); #3;
      chk("to_err_c16", 32'(BUS_ERR), 32'h1);
      cyc(); #3;
      chk("to_idle_act", 32'(CYCLE_ACTIVE), 32'h0);
`else
      for (int k = 1; k <= 40; k++) begin
        cyc(); ALE = 1'b0; #3;
        if (BUS_ERR) early_err = 1'b1;
      end
      chk("nto_no_err",  32'(early_err), 32'h0);
      chk("nto_act_c40", 32'(CYCLE_ACTIVE), 32'h1);
      chk("nto_cs_c40",  32'(CS), 32'h1);
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
